stream_arb_mux: RTL and testbench
=================================

// Module: stream_arb_mux
// PURPOSE
//  Parametrised N-channel, W-bit registered stream multiplexer; successor to the 4:1 bit mux.
//  Selects one of NUM_CH valid/ready input streams by fixed-priority or round-robin arbitration.
//  A manual select override is also supported. The selected stream drives one registered output stream.
//  Sits between per-channel producers and a shared downstream consumer (bus/FIFO/serialiser).
// PARAMETERS
//  NUM_CH    4   number of input channels, >=2
//  DATA_W    8   data width per channel, >=1
//  ARB_MODE  1   0 = fixed priority (lowest index wins), 1 = round-robin
//  CH_W      $clog2(NUM_CH)   derived, channel index width; not overridable
// PORTS
//  clk          in   1              single clock, all logic rising-edge
//  rst_n        in   1              asynchronous, active-low reset
//  in_valid     in   NUM_CH         per-channel valid
//  in_data      in   NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//  in_last      in   NUM_CH         end-of-packet marker; used only with STREAM_ARB_MUX_LOCK_EN
//  in_ready     out  NUM_CH         per-channel ready (one-hot or zero)
//  sel_force_en in   1              1 = bypass arbitration, serve only channel sel_force
//  sel_force    in   CH_W           forced channel index
//  out_valid    out  1              registered output valid
//  out_data     out  DATA_W         registered output data
//  out_ch       out  CH_W           source channel of current out_data
//  out_last     out  1              registered copy of winning in_last
// BEHAVIOUR
//  - Reset (async assert, sync deassert externally): out_valid=0, out_data=0, out_ch=0, out_last=0, rr pointer=0, lock FSM=IDLE.
//  - Output stage: single register. Pipeline can load when load_en = !out_valid || out_ready.
//  - in_ready[i] = grant[i] & load_en; grant is combinational, at most one bit set, only on a valid channel.
//  - Beat accepted on channel i when in_valid[i]&&in_ready[i]; out_* updated next edge; latency 1 cycle.
//  - If load_en and no grant: out_valid clears when out_ready=1, holds otherwise. out_data holds when not loading.
//  - out_valid=1 && out_ready=0: out_* stable, all in_ready=0 (no drop, no overwrite).
//  - Full throughput: out_ready held 1 gives one beat per cycle.
//  - Fixed priority: lowest index with in_valid wins.
//  - Round-robin: search starts at ptr, wrapping NUM_CH-1 -> 0. On each accepted beat, ptr <= grant_idx+1 (mod NUM_CH).
//    ptr unchanged when nothing is accepted.
//  - Override: sel_force_en=1 -> grant = in_valid[sel_force] ? onehot(sel_force) : 0. ptr not updated.
//    sel_force >= NUM_CH -> no grant.
//  - Simultaneous: requests changing while out stalled have no effect. Grant is evaluated only in load_en cycles.
//  - in_valid withdrawn before acceptance is tolerated (no protocol check, no state change).
// CONFIGURATION
//  STREAM_ARB_MUX_LOCK_EN defined: packet lock FSM, states IDLE and LOCKED.
//   IDLE --(beat accepted, in_last=0)--> LOCKED(ch=grant_idx).
//   LOCKED --(beat accepted on locked ch with in_last=1)--> IDLE.
//   In LOCKED, grant is held on the locked ch only; arbitration and sel_force changes are deferred until IDLE.
//   ptr advances only on the packet's last beat.
//  Not defined: every beat is arbitrated independently; in_last is only forwarded to out_last.
// STRUCTURE
//  stream_arb_mux_pkg: arb_mode_e {ARB_FIXED=0, ARB_RR=1}, lock_state_e {LK_IDLE, LK_LOCKED},
//   function onehot2idx.
//  Sub-module rr_arbiter (combinational: req, ptr, mode -> one-hot grant + idx) via double-width rotate-mask.
//  Top holds output register, ptr register, override mux, optional lock FSM.
// TESTING
//  1 Reset mid-stream: rst_n=0 while out_valid=1 -> out_valid=0, out_ch=0 immediately; first post-reset grant ch0 (RR).
//  2 RR, NUM_CH=4, all valid, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; data per channel.
//  3 Fixed mode, in_valid=4'b1010 for 3 cycles -> out_ch=1 every cycle; ch3 in_ready stays 0.
//  4 Backpressure: out_ready=0 for 5 cycles with beat 0xA5 held -> out_data=0xA5 stable, in_ready=0;
//    release -> next beat 1 cycle later.
//  5 Override: sel_force_en=1, sel_force=2, all valid -> only ch2 served. sel_force=7 with NUM_CH=4 -> no output.
//  6 LOCK_EN: ch1 sends 3-beat packet (last on beat 3), ch0 valid throughout -> out_ch=1,1,1 then 0; no interleave.

Source files
------------

// File: rtl/stream_arb_mux_pkg.sv
// Shared types and helpers for the stream_arb_mux channel multiplexer.
package stream_arb_mux_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   typedef enum logic {
      LK_IDLE   = 1'b0,
      LK_LOCKED = 1'b1
   } lock_state_e;

   // Widest grant vector onehot2idx can decode.
   localparam int unsigned MAX_CH = 64;

   // Index of the set bit in a one-hot vector (0 when no bit is set).
   function automatic int unsigned onehot2idx(input logic [MAX_CH-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < MAX_CH; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Combinational arbiter: fixed priority (search from channel 0) or
// round-robin (search from ptr, wrapping), via a double-width rotate-mask.
module rr_arbiter
   import stream_arb_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   input  arb_mode_e         mode,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   idx
);

   logic [2*NUM_CH-1:0] dbl;
   logic [2*NUM_CH-1:0] rot_dbl;
   logic [NUM_CH-1:0]   rot;
   logic [CH_W-1:0]     base;
   logic                found;
   int unsigned         pos;

   // Rotate requests so the search start sits at bit 0, take the first set
   // bit, then map the rotated position back to a channel number.
   always_comb begin
      base    = (mode == ARB_RR) ? ptr : '0;
      dbl     = {req, req};
      rot_dbl = dbl >> base;
      rot     = rot_dbl[NUM_CH-1:0];
      grant   = '0;
      found   = 1'b0;
      pos     = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            pos   = int'(base) + i;
            if (pos >= NUM_CH) pos = pos - NUM_CH;
            grant[pos] = 1'b1;
         end
      end
      idx = CH_W'(onehot2idx(MAX_CH'(grant)));
   end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Optional packet lock (no interleaving within a packet): define
// STREAM_ARB_MUX_LOCK_EN. Default build arbitrates every beat independently.
module stream_arb_mux
   import stream_arb_mux_pkg::*;
#(
   parameter  int NUM_CH   = 4,
   parameter  int DATA_W   = 8,
   parameter  int ARB_MODE = 1,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_last,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic                     sel_force_en,
   input  logic [CH_W-1:0]          sel_force,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic                     out_last,
   input  logic                     out_ready
);

   localparam arb_mode_e MODE = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;

   logic                load_en;
   logic [CH_W-1:0]     ptr;
   logic [CH_W-1:0]     ptr_nxt;
   logic                ptr_adv;
   logic [NUM_CH-1:0]   arb_grant;
   logic [CH_W-1:0]     arb_idx;
   logic [NUM_CH-1:0]   force_grant;
   logic [NUM_CH-1:0]   sel_grant;
   logic [CH_W-1:0]     sel_idx;
   logic                use_arb;
   logic                accept;
   logic [DATA_W-1:0]   win_data;
   logic                win_last;

`ifdef STREAM_ARB_MUX_LOCK_EN
   lock_state_e         lk_state, lk_next;
   logic [CH_W-1:0]     lk_ch, lk_ch_next;
   logic                lk_arb, lk_arb_next;
`endif

   assign load_en = !out_valid || out_ready;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .req    (in_valid),
      .ptr    (ptr),
      .mode   (MODE),
      .grant  (arb_grant),
      .idx    (arb_idx)
   );

   // Forced channel: granted only if in range and valid.
   always_comb begin
      force_grant = '0;
      if (int'(sel_force) < NUM_CH) begin
         if (in_valid[sel_force]) force_grant[sel_force] = 1'b1;
      end
   end

   // Grant source: locked channel, then override, then arbiter.
   always_comb begin
      sel_grant = '0;
      sel_idx   = '0;
      use_arb   = 1'b0;
`ifdef STREAM_ARB_MUX_LOCK_EN
      if (lk_state == LK_LOCKED) begin
         if (in_valid[lk_ch]) sel_grant[lk_ch] = 1'b1;
         sel_idx = lk_ch;
      end else
`endif
      if (sel_force_en) begin
         sel_grant = force_grant;
         sel_idx   = sel_force;
      end else begin
         sel_grant = arb_grant;
         sel_idx   = arb_idx;
         use_arb   = 1'b1;
      end
   end

   assign in_ready = load_en ? sel_grant : '0;
   assign accept   = load_en && (|sel_grant);

   // AND-OR mux of the granted channel's payload (grant is one-hot).
   always_comb begin
      win_data = '0;
      win_last = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (sel_grant[i]) begin
            win_data = in_data[i*DATA_W +: DATA_W];
            win_last = in_last[i];
         end
      end
   end

   // Round-robin pointer advance: only for arbitrated beats (or packets).
   always_comb begin
      ptr_nxt = (int'(sel_idx) == NUM_CH - 1) ? '0 : sel_idx + 1'b1;
`ifdef STREAM_ARB_MUX_LOCK_EN
      ptr_adv = accept && win_last &&
                (use_arb || ((lk_state == LK_LOCKED) && lk_arb));
`else
      ptr_adv = accept && use_arb;
`endif
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ptr <= '0;
      else if (ptr_adv) ptr <= ptr_nxt;
   end

   // Output stage: load on accept, clear when drained with nothing to load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= win_data;
         out_ch    <= sel_idx;
         out_last  <= win_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef STREAM_ARB_MUX_LOCK_EN
   // Lock state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lk_state <= LK_IDLE;
         lk_ch    <= '0;
         lk_arb   <= 1'b0;
      end else begin
         lk_state <= lk_next;
         lk_ch    <= lk_ch_next;
         lk_arb   <= lk_arb_next;
      end
   end

   // Lock next-state: enter on a non-last beat, leave on the last beat.
   always_comb begin
      lk_next     = lk_state;
      lk_ch_next  = lk_ch;
      lk_arb_next = lk_arb;
      case (lk_state)
         LK_IDLE: begin
            if (accept && !win_last) begin
               lk_next     = LK_LOCKED;
               lk_ch_next  = sel_idx;
               lk_arb_next = use_arb;
            end
         end
         LK_LOCKED: begin
            if (accept && win_last) lk_next = LK_IDLE;
         end
         default: lk_next = LK_IDLE;
      endcase
   end
`endif

endmodule

// File: tb/tb_stream_arb_mux.sv
// Self-checking bench for stream_arb_mux: round-robin, fixed-priority and
// 3-channel instances; scoreboard on the round-robin output stream.
`timescale 1ns/1ps
module tb_stream_arb_mux;

   logic        clk = 1'b0;
   logic        rst_n;

   // round-robin, 4 channels
   logic [3:0]  in_valid, in_last, in_ready;
   logic [31:0] in_data;
   logic        sel_force_en;
   logic [1:0]  sel_force;
   logic        out_valid, out_last, out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;

   // fixed priority, 4 channels
   logic [3:0]  fx_in_valid, fx_in_ready;
   logic        fx_sel_force_en;
   logic [1:0]  fx_sel_force;
   logic        fx_out_valid, fx_out_last, fx_out_ready;
   logic [7:0]  fx_out_data;
   logic [1:0]  fx_out_ch;

   // round-robin, 3 channels
   logic [2:0]  n3_in_valid, n3_in_last, n3_in_ready;
   logic [23:0] n3_in_data;
   logic        n3_sel_force_en;
   logic [1:0]  n3_sel_force;
   logic        n3_out_valid, n3_out_last, n3_out_ready;
   logic [7:0]  n3_out_data;
   logic [1:0]  n3_out_ch;

   typedef struct {
      logic [1:0] ch;
      logic [7:0] data;
      logic       last;
   } beat_t;

   beat_t sb[$];
   int    n_total = 0;
   int    n_bad   = 0;

   always #5 clk = ~clk;

   stream_arb_mux #(.NUM_CH(4), .DATA_W(8), .ARB_MODE(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .sel_force_en(sel_force_en), .sel_force(sel_force),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_last(out_last), .out_ready(out_ready)
   );

   stream_arb_mux #(.NUM_CH(4), .DATA_W(8), .ARB_MODE(0)) u_fx (
      .clk(clk), .rst_n(rst_n),
      .in_valid(fx_in_valid), .in_data(in_data), .in_last(in_last), .in_ready(fx_in_ready),
      .sel_force_en(fx_sel_force_en), .sel_force(fx_sel_force),
      .out_valid(fx_out_valid), .out_data(fx_out_data), .out_ch(fx_out_ch),
      .out_last(fx_out_last), .out_ready(fx_out_ready)
   );

   stream_arb_mux #(.NUM_CH(3), .DATA_W(8), .ARB_MODE(1)) u_n3 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(n3_in_valid), .in_data(n3_in_data), .in_last(n3_in_last), .in_ready(n3_in_ready),
      .sel_force_en(n3_sel_force_en), .sel_force(n3_sel_force),
      .out_valid(n3_out_valid), .out_data(n3_out_data), .out_ch(n3_out_ch),
      .out_last(n3_out_last), .out_ready(n3_out_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] ch, input logic [7:0] data, input logic last);
      beat_t b;
      b.ch = ch; b.data = data; b.last = last;
      sb.push_back(b);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: each beat consumed by the downstream must match the queue head.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            check("sb_extra", {30'd0, out_ch}, 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = sb.pop_front();
            check("sb_ch",   {30'd0, out_ch},   {30'd0, e.ch});
            check("sb_data", {24'd0, out_data}, {24'd0, e.data});
            check("sb_last", {31'd0, out_last}, {31'd0, e.last});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = '0; in_last = '1; in_data = {8'h44, 8'h33, 8'h22, 8'h11};
      sel_force_en = 1'b0; sel_force = '0; out_ready = 1'b0;
      fx_in_valid = '0; fx_sel_force_en = 1'b0; fx_sel_force = '0; fx_out_ready = 1'b0;
      n3_in_valid = '0; n3_in_last = '1; n3_in_data = {8'h33, 8'h22, 8'h11};
      n3_sel_force_en = 1'b0; n3_sel_force = '0; n3_out_ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data",  {24'd0, out_data},  32'd0);
      check("rst_ch",    {30'd0, out_ch},    32'd0);
      check("rst_last",  {31'd0, out_last},  32'd0);
      rst_n = 1'b1;
      tick();

      // round-robin over all channels: 0,1,2,3,0
      in_valid = 4'hF; out_ready = 1'b1;
      #1 check("rr_rdy0", {28'd0, in_ready}, 32'h1);
      push(2'd0, 8'h11, 1'b1); push(2'd1, 8'h22, 1'b1); push(2'd2, 8'h33, 1'b1);
      push(2'd3, 8'h44, 1'b1); push(2'd0, 8'h11, 1'b1);
      repeat (5) tick();
      in_valid = '0;
      tick(); tick();
      check("rr_idle", {31'd0, out_valid}, 32'd0);

      // reset while a beat is held
      in_valid = 4'b0010; out_ready = 1'b0;
      tick();
      in_valid = '0;
      check("rst_pre_valid", {31'd0, out_valid}, 32'd1);
      check("rst_pre_ch",    {30'd0, out_ch},    32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mid_ch",    {30'd0, out_ch},    32'd0);
      check("rst_mid_data",  {24'd0, out_data},  32'd0);
      tick();
      rst_n = 1'b1;
      in_valid = 4'hF; out_ready = 1'b1;
      #1 check("rst_first_rdy", {28'd0, in_ready}, 32'h1);
      push(2'd0, 8'h11, 1'b1);
      tick();
      in_valid = '0;
      tick(); tick();

      // backpressure: 0xA5 held for 5 stalled cycles
      in_data[23:16] = 8'hA5; in_valid = 4'b0100; out_ready = 1'b0;
      #1 check("bp_rdy_load", {28'd0, in_ready}, 32'h4);
      push(2'd2, 8'hA5, 1'b1); push(2'd2, 8'h5A, 1'b1);
      tick();
      in_data[23:16] = 8'h5A;
      for (int i = 0; i < 5; i++) begin
         check("bp_data",  {24'd0, out_data},  32'hA5);
         check("bp_rdy",   {28'd0, in_ready},  32'h0);
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         tick();
      end
      out_ready = 1'b1;
      #1 check("bp_rdy_rel", {28'd0, in_ready}, 32'h4);
      tick();
      in_valid = '0;
      check("bp_next", {24'd0, out_data}, 32'h5A);
      tick(); tick();
      in_data[23:16] = 8'h33;

      // override on channel 2; pointer must stay put
      sel_force_en = 1'b1; sel_force = 2'd2; in_valid = 4'hF;
      #1 check("ovr_rdy0", {28'd0, in_ready}, 32'h4);
      push(2'd2, 8'h33, 1'b1); push(2'd2, 8'h33, 1'b1); push(2'd2, 8'h33, 1'b1);
      repeat (3) begin
         tick();
         check("ovr_rdy", {28'd0, in_ready}, 32'h4);
      end
      in_valid = '0; sel_force_en = 1'b0;
      tick(); tick();

      // round-robin resumes at 3 and wraps to 0
      in_valid = 4'hF;
      #1 check("rr_wrap_rdy", {28'd0, in_ready}, 32'h8);
      push(2'd3, 8'h44, 1'b1); push(2'd0, 8'h11, 1'b1);
      tick(); tick();
      in_valid = '0;
      tick(); tick();

      // 3-channel instance: out-of-range forced index grants nothing
      n3_in_valid = 3'b111; n3_sel_force_en = 1'b1; n3_sel_force = 2'd3; n3_out_ready = 1'b1;
      #1 check("n3_oor_rdy", {29'd0, n3_in_ready}, 32'h0);
      tick(); tick();
      check("n3_oor_valid", {31'd0, n3_out_valid}, 32'd0);
      n3_sel_force = 2'd2;
      #1 check("n3_f2_rdy", {29'd0, n3_in_ready}, 32'h4);
      tick();
      n3_in_valid = '0;
      check("n3_f2_ch",   {30'd0, n3_out_ch},   32'd2);
      check("n3_f2_data", {24'd0, n3_out_data}, 32'h33);

      // fixed priority: in_valid=1010 always serves channel 1
      fx_in_valid = 4'b1010; fx_out_ready = 1'b1;
      #1 check("fx_rdy0", {28'd0, fx_in_ready}, 32'h2);
      repeat (3) begin
         tick();
         check("fx_ch",    {30'd0, fx_out_ch},    32'd1);
         check("fx_data",  {24'd0, fx_out_data},  32'h22);
         check("fx_valid", {31'd0, fx_out_valid}, 32'd1);
         check("fx_rdy",   {28'd0, fx_in_ready},  32'h2);
      end
      fx_in_valid = '0;
      tick();

`ifdef STREAM_ARB_MUX_LOCK_EN
      // 3-beat packet on channel 1 with channel 0 waiting: no interleave
      in_valid = 4'b0011; in_last = 4'b1101;
      #1 check("lk_rdy0", {28'd0, in_ready}, 32'h2);
      push(2'd1, 8'h22, 1'b0); push(2'd1, 8'h22, 1'b0);
      push(2'd1, 8'h22, 1'b1); push(2'd0, 8'h11, 1'b1);
      tick();
      check("lk_hold", {28'd0, in_ready}, 32'h2);
      tick();
      in_last = 4'b1111;
      check("lk_hold2", {28'd0, in_ready}, 32'h2);
      tick();
      check("lk_release", {28'd0, in_ready}, 32'h1);
      tick();
      in_valid = '0;
      tick(); tick();
`else
      // non-final beat: in_last forwarded as 0
      in_valid = 4'b0011; in_last = 4'b1101;
      #1 check("last_rdy0", {28'd0, in_ready}, 32'h2);
      push(2'd1, 8'h22, 1'b0); push(2'd0, 8'h11, 1'b1);
      tick();
      check("last_next_rdy", {28'd0, in_ready}, 32'h1);
      tick();
      in_valid = '0; in_last = 4'b1111;
      tick(); tick();
`endif

      check("sb_drain", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
